hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 13 +
 rtl/sat_counter.sv | 29 ++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      REDIR = 2'd1,
      MEMW  = 2'd2
   } hz_state_e;

   localparam int XLEN_DEF  = 64;
   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Advance only while below the saturation value.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, operand-not-ready bubbles
// and taken-branch redirects, with saturating stall/redirect counters.
//
// state | meaning
// RUN   | normal flow; accepts branches, applies forwarding stalls
// REDIR | redirect pending; holding target until IFP accepts it
// MEMW  | data memory busy; whole pipe held
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int NUM_FWD = 3,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               branch_taken_EXB,
   input  logic [XLEN-1:0]    branch_target_EXB,
   input  logic [NUM_FWD-1:0] no_fwd_data,
   input  logic               mem_busy,
   input  logic               ifp_ready,
   output logic               stall_IFP,
   output logic               stall_IFR,
   output logic               stall_IDC,
   output logic               stall_IDR,
   output logic               stall_EXB,
   output logic               stall_MEMP,
   output logic               nop_IDR,
   output logic               flush_IFR,
   output logic               flush_IDC,
   output logic               flush_IDR,
   output logic               flush_EXB,
   output logic               redirect_valid_IFP,
   output logic [XLEN-1:0]    redirect_target_IFP,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   redirect_cnt
);

   hz_state_e     state_q, state_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic          fwd_stall;
   logic          stall_all, stall_front, flush_front, redir_inc;

   assign fwd_stall = |no_fwd_data;

   // Next state and control decode; rst_n gates outputs so reset clears them
   // asynchronously, without waiting for an edge.
   always_comb begin
      state_d             = state_q;
      tgt_d               = tgt_q;
      stall_all           = 1'b0;
      stall_front         = 1'b0;
      nop_IDR             = 1'b0;
      flush_front         = 1'b0;
      redir_inc           = 1'b0;
      redirect_valid_IFP  = 1'b0;
      redirect_target_IFP = tgt_q;
      case (state_q)
         REDIR: begin
            redirect_valid_IFP = 1'b1;
            flush_front        = 1'b1;
            if (ifp_ready) state_d = RUN;
         end
         default: begin
            if (mem_busy) begin
               stall_all = 1'b1;
               state_d   = MEMW;
            end else begin
               state_d = RUN;
               if (branch_taken_EXB) begin
                  flush_front = 1'b1;
                  redir_inc   = 1'b1;
                  if (ifp_ready) begin
                     redirect_valid_IFP  = 1'b1;
                     redirect_target_IFP = branch_target_EXB;
                  end else begin
                     tgt_d   = branch_target_EXB;
                     state_d = REDIR;
                  end
               end else if (fwd_stall) begin
                  stall_front = 1'b1;
                  nop_IDR     = 1'b1;
               end
            end
         end
      endcase
      if (!rst_n) begin
         stall_all          = 1'b0;
         stall_front        = 1'b0;
         nop_IDR            = 1'b0;
         flush_front        = 1'b0;
         redir_inc          = 1'b0;
         redirect_valid_IFP = 1'b0;
      end
   end

   assign stall_IFP  = stall_all | stall_front;
   assign stall_IFR  = stall_all | stall_front;
   assign stall_IDC  = stall_all | stall_front;
   assign stall_IDR  = stall_all;
   assign stall_EXB  = stall_all;
   assign stall_MEMP = stall_all;
   assign flush_IFR  = flush_front;
   assign flush_IDC  = flush_front;
   assign flush_IDR  = flush_front;
   assign flush_EXB  = 1'b0;

   // State and latched redirect target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_IFP),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (redir_inc),
      .cnt   (redirect_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver predicts each cycle's outputs from
// a behavioural model and queues them; a monitor compares on the falling edge.
module tb_hazard_ctrl;

   localparam int XLEN = 64;
   localparam int NF   = 3;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            branch_taken_EXB;
   logic [XLEN-1:0] branch_target_EXB;
   logic [NF-1:0]   no_fwd_data;
   logic            mem_busy;
   logic            ifp_ready;
   logic stall_IFP, stall_IFR, stall_IDC, stall_IDR, stall_EXB, stall_MEMP;
   logic nop_IDR, flush_IFR, flush_IDC, flush_IDR, flush_EXB;
   logic            redirect_valid_IFP;
   logic [XLEN-1:0] redirect_target_IFP;
   logic [CW-1:0]   stall_cnt, redirect_cnt;

   hazard_ctrl #(.XLEN(XLEN), .NUM_FWD(NF), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .branch_taken_EXB(branch_taken_EXB), .branch_target_EXB(branch_target_EXB),
      .no_fwd_data(no_fwd_data), .mem_busy(mem_busy), .ifp_ready(ifp_ready),
      .stall_IFP(stall_IFP), .stall_IFR(stall_IFR), .stall_IDC(stall_IDC),
      .stall_IDR(stall_IDR), .stall_EXB(stall_EXB), .stall_MEMP(stall_MEMP),
      .nop_IDR(nop_IDR), .flush_IFR(flush_IFR), .flush_IDC(flush_IDC),
      .flush_IDR(flush_IDR), .flush_EXB(flush_EXB),
      .redirect_valid_IFP(redirect_valid_IFP), .redirect_target_IFP(redirect_target_IFP),
      .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]      stalls;   // IFP IFR IDC IDR EXB MEMP
      logic            nop;
      logic [3:0]      flushes;  // IFR IDC IDR EXB
      logic            rv;
      logic [XLEN-1:0] tgt;
      int unsigned     scnt;
      int unsigned     rcnt;
   } exp_t;

   exp_t expq[$];
   int checks = 0;
   int errors = 0;

   // Model state: a pending redirect and its target, plus event counts.
   bit              m_pending = 0;
   logic [XLEN-1:0] m_ptgt    = '0;
   int unsigned     m_scnt    = 0;
   int unsigned     m_rcnt    = 0;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One stimulus cycle: drive inputs just after the rising edge, predict outputs.
   task automatic cyc(input bit bt, input logic [XLEN-1:0] tgt, input logic [NF-1:0] nfd,
                      input bit mb, input bit rdy, input bit rn);
      exp_t e;
      @(posedge clk);
      #1;
      branch_taken_EXB  = bt;
      branch_target_EXB = tgt;
      no_fwd_data       = nfd;
      mem_busy          = mb;
      ifp_ready         = rdy;
      rst_n             = rn;
      e = '0;
      if (!rn) begin
         m_pending = 0; m_ptgt = '0; m_scnt = 0; m_rcnt = 0;
         expq.push_back(e);
         return;
      end
      e.scnt = m_scnt;
      e.rcnt = m_rcnt;
      if (m_pending) begin
         e.rv = 1; e.tgt = m_ptgt; e.flushes = 4'b1110;
         if (rdy) m_pending = 0;
      end else if (mb) begin
         e.stalls = 6'b111111;
      end else if (bt) begin
         e.flushes = 4'b1110;
         m_rcnt = (m_rcnt < CMAX) ? m_rcnt + 1 : CMAX;
         if (rdy) begin
            e.rv = 1; e.tgt = tgt;
         end else begin
            m_pending = 1; m_ptgt = tgt;
         end
      end else if (nfd != 0) begin
         e.stalls = 6'b111000; e.nop = 1;
      end
      if (e.stalls[5]) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
      expq.push_back(e);
   endtask

   // Monitor: compare presented outputs against the oldest prediction.
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t e;
         e = expq.pop_front();
         chk("stalls", {58'd0, stall_IFP, stall_IFR, stall_IDC, stall_IDR, stall_EXB, stall_MEMP},
             {58'd0, e.stalls});
         chk("nop_IDR", {63'd0, nop_IDR}, {63'd0, e.nop});
         chk("flushes", {60'd0, flush_IFR, flush_IDC, flush_IDR, flush_EXB}, {60'd0, e.flushes});
         chk("redirect_valid", {63'd0, redirect_valid_IFP}, {63'd0, e.rv});
         if (e.rv) chk("redirect_target", redirect_target_IFP, e.tgt);
         chk("stall_cnt", {60'd0, stall_cnt}, XLEN'(e.scnt));
         chk("redirect_cnt", {60'd0, redirect_cnt}, XLEN'(e.rcnt));
      end
   end

   initial begin
      logic [XLEN-1:0] t;
      rst_n = 0; branch_taken_EXB = 0; branch_target_EXB = '0;
      no_fwd_data = '0; mem_busy = 0; ifp_ready = 0;
      // reset, with busy inputs to show outputs are forced low
      cyc(1, 64'h1234, 3'b111, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      // accepted branch, IFP ready
      cyc(1, 64'h8000_0040, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 1);
      // accepted branch, IFP stalls 3 cycles
      cyc(1, 64'hCAFE_0100, 0, 0, 0, 1);
      cyc(1, 64'h1111, 0, 0, 0, 1);
      cyc(1, 64'h2222, 3'b001, 1, 0, 1);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 1);
      // memory wait with branch held
      cyc(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 64'h4000_0000, 0, 1, 1, 1);
      cyc(1, 64'h4000_0000, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 1);
      // operand not ready, then branch overriding it
      cyc(0, 0, 3'b010, 0, 1, 1);
      cyc(0, 0, 3'b010, 0, 1, 1);
      cyc(1, 64'h77, 3'b010, 0, 1, 1);
      // stall counter saturation
      for (int i = 0; i < 20; i++) cyc(0, 0, 3'b100, 0, 1, 1);
      // reset mid-REDIR
      cyc(1, 64'hDEAD_BEE0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      // reset mid-MEMW
      cyc(0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         t = {$urandom, $urandom};
         cyc(($urandom_range(0, 2) == 0), t,
             ($urandom_range(0, 1) == 0) ? 3'b000 : NF'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
             ($urandom_range(0, 39) != 0));
      end
      repeat (3) @(posedge clk);
      chk("queue_drained", XLEN'(expq.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
